// File: rtl/rd_return_collector.sv
// rd_return_collector
//
// Matches read bursts returned by the PHY against the read commands issued by
// the dispatcher. Each issued read pushes a one-bit tag (1 = periodic read)
// into a tag FIFO. Each returned burst pops one tag:
//   - periodic bursts are presented once on pr_valid/pr_data (no backpressure)
//   - host bursts are buffered, then serialized LSB word first onto a
//     valid/ready stream
// Protocol errors are recorded in sticky bits that are cleared by err_clr.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_issue            one pulse per issued read command
//   rd_issue_pr         qualifies rd_issue: 1 = periodic read
//   dfi_rddata_valid    PHY returned-burst strobe
//   dfi_rddata          PHY returned burst
//   out_valid/out_ready host stream handshake
//   out_data, out_last  host stream word, final word of a burst
//   pr_valid, pr_data   periodic-read single-cycle pulse and burst
//   outstanding         registered tag FIFO occupancy
//   err_clr             clears all sticky errors
//   tag_overflow        issue while tag FIFO full
//   orphan_err          data returned with no tag queued
//   drop_err            host burst dropped because the burst buffer was full
//   timeout_err         reads outstanding for TIMEOUT cycles with no return
module rd_return_collector #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned OUT_WIDTH  = 64,
  parameter int unsigned TAG_DEPTH  = 16,
  parameter int unsigned DBUF_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_issue,
  input  logic                         rd_issue_pr,
  input  logic                         dfi_rddata_valid,
  input  logic [DATA_WIDTH-1:0]        dfi_rddata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_last,
  output logic                         pr_valid,
  output logic [DATA_WIDTH-1:0]        pr_data,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  input  logic                         err_clr,
  output logic                         tag_overflow,
  output logic                         orphan_err,
  output logic                         drop_err,
  output logic                         timeout_err
);

  localparam int unsigned Words  = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned IdxW   = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned TagAw  = $clog2(TAG_DEPTH);
  localparam int unsigned DbufAw = $clog2(DBUF_DEPTH);
  localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);

  localparam logic [IdxW-1:0]  LastIdx    = IdxW'(Words - 1);
  localparam logic [TagAw:0]   TagCntMax  = TAG_DEPTH[TagAw:0];
  localparam logic [DbufAw:0]  DbufCntMax = DBUF_DEPTH[DbufAw:0];
  localparam logic [TmoW-1:0]  TmoMax     = TIMEOUT[TmoW-1:0];

  typedef enum logic {StIdle, StSend} state_t;

  // ---------------------------------------------------------------------------
  // Tag FIFO
  // ---------------------------------------------------------------------------
  logic             tag_mem [TAG_DEPTH];
  logic [TagAw-1:0] tag_wr_q, tag_rd_q;
  logic [TagAw:0]   tag_cnt_q, tag_cnt_d;
  logic             tag_full, tag_empty, tag_push, tag_pop, tag_head;

  assign tag_full  = (tag_cnt_q == TagCntMax);
  assign tag_empty = (tag_cnt_q == '0);
  // Pops see only registered occupancy: a same-cycle push cannot satisfy data.
  assign tag_pop   = dfi_rddata_valid & ~tag_empty;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign tag_push  = rd_issue & (~tag_full | tag_pop);
  assign tag_head  = tag_mem[tag_rd_q];

  always_comb begin
    tag_cnt_d = tag_cnt_q;
    if (tag_push && !tag_pop) begin
      tag_cnt_d = tag_cnt_q + 1'b1;
    end else if (!tag_push && tag_pop) begin
      tag_cnt_d = tag_cnt_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst routing
  // ---------------------------------------------------------------------------
  logic pr_evt, host_evt;
  assign pr_evt   = tag_pop & tag_head;
  assign host_evt = tag_pop & ~tag_head;

  // ---------------------------------------------------------------------------
  // Host burst buffer
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] dbuf_mem [DBUF_DEPTH];
  logic [DbufAw-1:0]     dbuf_wr_q, dbuf_rd_q;
  logic [DbufAw:0]       dbuf_cnt_q, dbuf_cnt_d;
  logic                  dbuf_full, dbuf_wr, burst_pop;

  state_t          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;

  assign dbuf_full = (dbuf_cnt_q == DbufCntMax);
  // Last word accepted: the head burst leaves the buffer this cycle.
  assign burst_pop = (state_q == StSend) & out_ready & (idx_q == LastIdx);
  assign dbuf_wr   = host_evt & (~dbuf_full | burst_pop);

  always_comb begin
    dbuf_cnt_d = dbuf_cnt_q;
    if (dbuf_wr && !burst_pop) begin
      dbuf_cnt_d = dbuf_cnt_q + 1'b1;
    end else if (!dbuf_wr && burst_pop) begin
      dbuf_cnt_d = dbuf_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[tag_wr_q] <= rd_issue_pr;
    end
    if (dbuf_wr) begin
      dbuf_mem[dbuf_wr_q] <= dfi_rddata;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (dbuf_cnt_q != '0) begin
          state_d = StSend;
          idx_d   = '0;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d = '0;
            // Stay in SEND when another burst is waiting so bursts run back to back.
            if (dbuf_cnt_d == '0) begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  logic [OUT_WIDTH-1:0] out_word;

  always_comb begin
    out_word = '0;
    for (int unsigned i = 0; i < Words; i++) begin
      if (idx_q == IdxW'(i)) begin
        out_word = dbuf_mem[dbuf_rd_q][i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  assign out_valid = (state_q == StSend);
  assign out_data  = out_valid ? out_word : '0;
  assign out_last  = out_valid & (idx_q == LastIdx);

  // ---------------------------------------------------------------------------
  // Timeout counter
  // ---------------------------------------------------------------------------
  logic [TmoW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (tag_pop || tag_empty) begin
      tmo_d = '0;
    end else if (tmo_q != TmoMax) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic                  pr_valid_q;
  logic [DATA_WIDTH-1:0] pr_data_q;
  logic                  ovf_q, orphan_q, drop_q, tmo_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      tag_cnt_q  <= '0;
      dbuf_wr_q  <= '0;
      dbuf_rd_q  <= '0;
      dbuf_cnt_q <= '0;
      state_q    <= StIdle;
      idx_q      <= '0;
      tmo_q      <= '0;
      pr_valid_q <= 1'b0;
      pr_data_q  <= '0;
      ovf_q      <= 1'b0;
      orphan_q   <= 1'b0;
      drop_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      if (tag_push)  tag_wr_q  <= tag_wr_q + 1'b1;
      if (tag_pop)   tag_rd_q  <= tag_rd_q + 1'b1;
      if (dbuf_wr)   dbuf_wr_q <= dbuf_wr_q + 1'b1;
      if (burst_pop) dbuf_rd_q <= dbuf_rd_q + 1'b1;
      tag_cnt_q  <= tag_cnt_d;
      dbuf_cnt_q <= dbuf_cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      pr_valid_q <= pr_evt;
      if (pr_evt) pr_data_q <= dfi_rddata;
      // A new error event in the clear cycle keeps its bit set.
      ovf_q     <= (ovf_q & ~err_clr)     | (rd_issue & tag_full & ~tag_pop);
      orphan_q  <= (orphan_q & ~err_clr)  | (dfi_rddata_valid & tag_empty);
      drop_q    <= (drop_q & ~err_clr)    | (host_evt & dbuf_full & ~burst_pop);
      tmo_err_q <= (tmo_err_q & ~err_clr) | (tmo_q == TmoMax);
    end
  end

  assign pr_valid     = pr_valid_q;
  assign pr_data      = pr_data_q;
  assign outstanding  = tag_cnt_q;
  assign tag_overflow = ovf_q;
  assign orphan_err   = orphan_q;
  assign drop_err     = drop_q;
  assign timeout_err  = tmo_err_q;

endmodule

// File: tb/tb_rd_return_collector.sv
module tb_rd_return_collector;

  localparam int DW    = 512;
  localparam int OW    = 64;
  localparam int WORDS = DW / OW;

  logic          clk;
  logic          rst;
  logic          rd_issue;
  logic          rd_issue_pr;
  logic          dfi_rddata_valid;
  logic [DW-1:0] dfi_rddata;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          pr_valid;
  logic [DW-1:0] pr_data;
  logic [4:0]    outstanding;
  logic          err_clr;
  logic          tag_overflow;
  logic          orphan_err;
  logic          drop_err;
  logic          timeout_err;

  rd_return_collector #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .TAG_DEPTH (16),
    .DBUF_DEPTH(4),
    .TIMEOUT   (255)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rd_issue        (rd_issue),
    .rd_issue_pr     (rd_issue_pr),
    .dfi_rddata_valid(dfi_rddata_valid),
    .dfi_rddata      (dfi_rddata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .pr_valid        (pr_valid),
    .pr_data         (pr_data),
    .outstanding     (outstanding),
    .err_clr         (err_clr),
    .tag_overflow    (tag_overflow),
    .orphan_err      (orphan_err),
    .drop_err        (drop_err),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: host words as {last, data}; periodic bursts whole.
  logic [OW:0]   hq [$];
  logic [DW-1:0] pq [$];

  function automatic logic [DW-1:0] mk(input logic [63:0] base);
    logic [DW-1:0] b;
    for (int k = 0; k < WORDS; k++) b[k*OW +: OW] = base + 64'(k);
    return b;
  endfunction

  // Output monitor: every accepted word / periodic pulse is popped and compared.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (hq.size() == 0) begin
        failures++;
        $display("FAIL host_extra_word got=%h last=%b, none expected", out_data, out_last);
      end else begin
        logic [OW:0] e;
        e = hq.pop_front();
        if ({out_last, out_data} !== e) begin
          failures++;
          $display("FAIL host_word got last=%b data=%h, want last=%b data=%h",
                   out_last, out_data, e[OW], e[OW-1:0]);
        end
      end
    end
    if (!rst && pr_valid) begin
      checks++;
      if (pq.size() == 0) begin
        failures++;
        $display("FAIL pr_extra_pulse got=%h, none expected", pr_data[63:0]);
      end else begin
        logic [DW-1:0] e;
        e = pq.pop_front();
        if (pr_data !== e) begin
          failures++;
          $display("FAIL pr_data got=%h want=%h (low word)", pr_data[63:0], e[63:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic pr);
    rd_issue    = 1'b1;
    rd_issue_pr = pr;
    tick();
    rd_issue    = 1'b0;
    rd_issue_pr = 1'b0;
  endtask

  // kind: 0 = nothing expected, 1 = host stream, 2 = periodic channel
  task automatic burst(input logic [DW-1:0] d, input int kind);
    dfi_rddata_valid = 1'b1;
    dfi_rddata       = d;
    if (kind == 1) begin
      for (int k = 0; k < WORDS; k++) hq.push_back({(k == WORDS - 1), d[k*OW +: OW]});
    end else if (kind == 2) begin
      pq.push_back(d);
    end
    tick();
    dfi_rddata_valid = 1'b0;
    dfi_rddata       = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((hq.size() != 0 || pq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (hq.size() != 0 || pq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain host_left=%0d pr_left=%0d, want 0/0", name, hq.size(), pq.size());
    end
    tick();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL %s_no_valid out_valid=%b after %0d cycles, want 1", name, out_valid, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, pr_valid} !== 3'b000 || out_data !== '0 || pr_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b last=%b pr_valid=%b, want all 0",
               out_valid, out_last, pr_valid);
    end
    checks++;
    if (outstanding !== 5'd0) begin
      failures++;
      $display("FAIL reset_outstanding got=%0d want=0", outstanding);
    end
    checks++;
    if ({tag_overflow, orphan_err, drop_err, timeout_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_errors got=%b want=0000",
               {tag_overflow, orphan_err, drop_err, timeout_err});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_host_two;
    int seen;
    out_ready = 1'b1;
    issue(1'b0);
    issue(1'b0);
    burst(mk(64'h1000), 1);
    burst(mk(64'h1008), 1);
    wait_valid("host_two");
    seen = 1;
    for (int i = 1; i < 2 * WORDS; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 2 * WORDS) begin
      failures++;
      $display("FAIL host_two_no_bubble valid_cycles=%0d want=%0d", seen, 2 * WORDS);
    end
    wait_drain("host_two");
    @(negedge clk);
    checks++;
    if (outstanding !== 5'd0) begin
      failures++;
      $display("FAIL host_two_outstanding got=%0d want=0", outstanding);
    end
    tick();
  endtask

  task automatic test_periodic;
    int pr_cnt, ov_cnt;
    issue(1'b1);
    burst(mk(64'hABC0_0000), 2);
    pr_cnt = 0;
    ov_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pr_valid) pr_cnt++;
      if (out_valid) ov_cnt++;
    end
    checks++;
    if (pr_cnt != 1) begin
      failures++;
      $display("FAIL periodic_pulse_width got=%0d cycles want=1", pr_cnt);
    end
    checks++;
    if (ov_cnt != 0) begin
      failures++;
      $display("FAIL periodic_host_leak out_valid_cycles=%0d want=0", ov_cnt);
    end
    wait_drain("periodic");
  endtask

  task automatic test_interleave;
    issue(1'b0);
    issue(1'b1);
    issue(1'b0);
    burst(mk(64'hA000), 1);
    burst(mk(64'hB000), 2);
    burst(mk(64'hC000), 1);
    wait_drain("interleave");
    @(negedge clk);
    checks++;
    if (outstanding !== 5'd0) begin
      failures++;
      $display("FAIL interleave_outstanding got=%0d want=0", outstanding);
    end
    tick();
  endtask

  task automatic test_stall;
    logic pat [9];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    issue(1'b0);
    burst(mk(64'h5100), 1);
    wait_valid("stall");
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1 out_ready = pat[i];
      @(negedge clk);
      if (i >= 1 && i <= 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h5102) begin
          failures++;
          $display("FAIL stall_hold cycle=%0d valid=%b data=%h want valid=1 data=5102",
                   i, out_valid, out_data);
        end
      end
    end
    out_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_drop;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(1'b0);
    for (int i = 0; i < 5; i++) burst(mk(64'h7000 + 64'(i * 16)), (i < 4) ? 1 : 0);
    @(negedge clk);
    checks++;
    if (drop_err !== 1'b1) begin
      failures++;
      $display("FAIL drop_set got=%b want=1", drop_err);
    end
    tick();
    out_ready = 1'b1;
    wait_drain("drop");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (drop_err !== 1'b0) begin
      failures++;
      $display("FAIL drop_clear got=%b want=0", drop_err);
    end
    tick();
  endtask

  task automatic test_orphan;
    burst(mk(64'hDEAD), 0);
    @(negedge clk);
    checks++;
    if (orphan_err !== 1'b1) begin
      failures++;
      $display("FAIL orphan_set got=%b want=1", orphan_err);
    end
    tick();
    // Clear and a new orphan event in the same cycle: the event wins.
    err_clr = 1'b1;
    burst(mk(64'hBEEF), 0);
    err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (orphan_err !== 1'b1) begin
      failures++;
      $display("FAIL orphan_clr_collision got=%b want=1", orphan_err);
    end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (orphan_err !== 1'b0) begin
      failures++;
      $display("FAIL orphan_clear got=%b want=0", orphan_err);
    end
    tick();
  endtask

  task automatic test_overflow_timeout;
    int n;
    for (int i = 0; i < 17; i++) issue(1'b0);
    @(negedge clk);
    checks++;
    if (tag_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set got=%b want=1", tag_overflow);
    end
    checks++;
    if (outstanding !== 5'd16) begin
      failures++;
      $display("FAIL overflow_outstanding got=%0d want=16", outstanding);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early got=%b want=0", timeout_err);
    end
    n = 0;
    while (!timeout_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!timeout_err || n < 220 || n > 250) begin
      failures++;
      $display("FAIL timeout_set got=%b after %0d cycles want=1 after 220..250",
               timeout_err, n);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tag_overflow, timeout_err} !== 2'b00 || outstanding !== 5'd0) begin
      failures++;
      $display("FAIL reset_clears ovf=%b tmo=%b outstanding=%0d want 0/0/0",
               tag_overflow, timeout_err, outstanding);
    end
    tick();
    out_ready = 1'b0;
    issue(1'b0);
    issue(1'b0);
    burst(mk(64'h9000), 1);
    wait_valid("reset_mid");
    @(posedge clk);
    #1 rst = 1'b1;
    hq.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || outstanding !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid out_valid=%b outstanding=%0d want 0/0", out_valid, outstanding);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    issue(1'b0);
    burst(mk(64'hE000), 1);
    wait_drain("after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    rd_issue         = 1'b0;
    rd_issue_pr      = 1'b0;
    dfi_rddata_valid = 1'b0;
    dfi_rddata       = '0;
    out_ready        = 1'b0;
    err_clr          = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_host_two();
    test_periodic();
    test_interleave();
    test_stall();
    test_drop();
    test_orphan();
    test_overflow_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rd_return_collector.md
Name: rd_return_collector

Overview:
Receives read data returned by the PHY over the DFI read interface and matches each returned burst against the read commands issued by the instruction dispatcher. Host reads are buffered and serialized onto a narrow valid/ready stream toward the host interface. Periodic reads are diverted to a separate single-cycle pulse channel. Protocol errors (orphan data, overflow, timeout, dropped data) are flagged as sticky bits.

Parameters:
DATA_WIDTH, 512, width of one DFI read burst (dfi_rddata)
OUT_WIDTH, 64, host stream word width; DATA_WIDTH must be an integer multiple of it
TAG_DEPTH, 16, outstanding-read tag FIFO depth (power of 2)
DBUF_DEPTH, 4, host burst buffer depth in bursts (power of 2)
TIMEOUT, 255, cycles without returned data, while reads are outstanding, before timeout_err is set

Ports:
clk  in  1  clock
rst  in  1  reset
rd_issue  in  1  one pulse per read command issued (driven from dfi_rddata_en)
rd_issue_pr  in  1  qualifies rd_issue: 1 means periodic read (driven from dfi_rddata_en_odd)
dfi_rddata_valid  in  1  PHY returned-burst strobe
dfi_rddata  in  DATA_WIDTH  PHY returned burst
out_valid  out  1  host stream word valid
out_ready  in  1  host stream accept
out_data  out  OUT_WIDTH  host stream word
out_last  out  1  final word of a burst
pr_valid  out  1  periodic-read data pulse
pr_data  out  DATA_WIDTH  periodic-read burst
outstanding  out  log2(TAG_DEPTH)+1  tags currently queued
err_clr  in  1  clears all sticky errors
tag_overflow  out  1  sticky error: rd_issue arrived while tag FIFO full
orphan_err  out  1  sticky error: data arrived with no tag queued
drop_err  out  1  sticky error: host burst arrived while burst buffer full
timeout_err  out  1  sticky error: read-return timeout

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset, all outputs are 0, all FIFOs are empty, the timeout counter is 0, and the serializer is in IDLE. Reset mid-burst discards all buffered data and tags.
- Tag push:
  - rd_issue pushes rd_issue_pr into the tag FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the push is ignored and tag_overflow is set.
  - A push and a pop in the same cycle while full are both accepted.
- Tag pop: every dfi_rddata_valid pops one tag.
  - Tag FIFO empty (and no same-cycle push): no pop; data discarded; orphan_err set. A same-cycle push into an empty FIFO does not satisfy the pop.
  - Popped tag = 1: pr_data is registered with dfi_rddata and pr_valid pulses high for exactly 1 cycle (the cycle after valid). No backpressure on this channel.
  - Popped tag = 0: the burst is written into the burst buffer. If the buffer is full, the burst is dropped, the tag is still consumed, and drop_err is set. A burst pop in the same cycle frees a slot and the write is accepted.
- outstanding = tag FIFO occupancy, registered, updated the cycle after push/pop.
- Serializer FSM, states IDLE and SEND:
  - IDLE -> SEND when the buffer is non-empty; word index = 0.
  - SEND: out_valid = 1; out_data = burst[idx*OUT_WIDTH +: OUT_WIDTH], LSB word first. out_last = 1 when idx = DATA_WIDTH/OUT_WIDTH - 1.
  - On out_valid & out_ready: idx increments. On the last word, pop the burst; stay in SEND with idx = 0 if the buffer still holds data (no bubble), else go to IDLE.
  - out_data and out_last are stable while out_valid & ~out_ready.
- Latency: a host burst arriving with dfi_rddata_valid at cycle N produces its first out_valid at cycle N+1 at the earliest.
- Timeout counter:
  - Clears on any pop, and when the tag FIFO is empty.
  - Otherwise increments while the tag FIFO is non-empty, saturating at TIMEOUT.
  - Reaching TIMEOUT sets timeout_err.
- Sticky errors: err_clr clears them the next cycle. An error event in the same cycle as err_clr wins (bit stays set).

Test Plan:
- 2x rd_issue(pr=0), then 2 bursts with word k = 64'h1000+k -> 16 words out in order, out_last on words 7 and 15, no bubble between bursts with out_ready=1, outstanding returns to 0.
- rd_issue(pr=1), then burst D -> pr_valid high exactly 1 cycle with pr_data = D; out_valid stays 0.
- Interleaved issues pr=0,1,0 with bursts A,B,C -> A and C on the host stream, B on pr_data; order preserved.
- out_ready toggling 1-0-0-1 mid-burst -> out_data held while stalled; all 8 words delivered exactly once.
- 5 host bursts with out_ready=0 (DBUF_DEPTH=4) -> drop_err=1, bursts 1-4 delivered after out_ready=1; err_clr -> drop_err=0.
- dfi_rddata_valid with no issue -> orphan_err=1. 17 issues with no data -> tag_overflow=1, outstanding=16, timeout_err=1 after 255 cycles. rst mid-SEND -> out_valid=0 and outstanding=0 next cycle.
